// File: rtl/me_sequencer_if.sv
// me_sequencer_if -- handshake and ROM-address bundle of the motion-estimation
// sequencer.
//   start      : level request from the controlling block, held for the search
//   completed  : search finished, held until start drops
//   busy       : search in progress
//   AddressR   : reference block ROM address (16x16, row-major)
//   AddressS1  : search window ROM port 1 address (32x32, row-major)
//   AddressS2  : search window ROM port 2 address
//   S1S2mux    : per-PE operand select (1 = S1, 0 = S2)
//   newDist    : one-hot "PE k distance valid" strobe
//   vecY       : vertical candidate index accompanying newDist
// master = controlling block, slave = sequencer.
interface me_sequencer_if;
    logic        start;
    logic        completed;
    logic        busy;
    logic [7:0]  AddressR;
    logic [9:0]  AddressS1;
    logic [9:0]  AddressS2;
    logic [15:0] S1S2mux;
    logic [15:0] newDist;
    logic [3:0]  vecY;

    modport master (
        output start,
        input  completed, busy, AddressR, AddressS1, AddressS2,
               S1S2mux, newDist, vecY
    );

    modport slave (
        input  start,
        output completed, busy, AddressR, AddressS1, AddressS2,
               S1S2mux, newDist, vecY
    );
endinterface

// File: rtl/me_sequencer.sv
// me_sequencer -- address/strobe sequencer for a 16-PE full-search motion
// estimator (16x16 reference block against a 32x32 search window).
//   clock : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : me_sequencer_if.slave (start in; status, ROM addresses, PE select,
//           distance strobes and vecY out)
// A 13-bit counter walks v (vertical candidate), r (block row) and c (column)
// for 4096 cycles, followed by 16 drain cycles that flush the last row of
// distances. ROM addresses are combinational; PE controls are registered so
// they line up with the one-cycle synchronous ROM read.
module me_sequencer (
    input  logic           clock,
    input  logic           reset,
    me_sequencer_if.slave  bus
);

    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_RUN    = 2'd1;
    localparam logic [1:0]  S_DONE   = 2'd2;
    localparam logic [12:0] CNT_LAST = 13'd4111;
    localparam logic [12:0] CNT_PIPE = 13'd256;  // first cycle with a full row behind it

    logic [1:0]  state_q, state_d;
    logic [12:0] cnt_q, cnt_d;
    logic [15:0] mux_q, mux_d;
    logic [15:0] nd_q, nd_d;
    logic [3:0]  vecy_q, vecy_d;

    logic [3:0] v, r, c;
    logic [4:0] rv;
    logic       in_win;
    logic       strobe_row;

    assign v = cnt_q[11:8];
    assign r = cnt_q[7:4];
    assign c = cnt_q[3:0];
    assign rv = {1'b0, r} + {1'b0, v};
    assign in_win = (state_q == S_RUN) && !cnt_q[12];
    // Row 0 of a vertical candidate is when the previous candidate's last row
    // has left every PE; the drain cycles (v wraps to 0) flush candidate 15.
    assign strobe_row = (cnt_q >= CNT_PIPE) && (r == 4'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (!bus.start) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end
            S_DONE: begin
                if (!bus.start) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Decode is suppressed on the abort cycle so no strobe follows a dropped start.
    always_comb begin
        mux_d  = '0;
        nd_d   = '0;
        vecy_d = '0;
        if (state_q == S_RUN && bus.start) begin
            for (int k = 0; k < 16; k++) begin
                mux_d[k] = !cnt_q[12] && (c >= 4'(k));
                nd_d[k]  = strobe_row && (c == 4'(k));
            end
            if (strobe_row) vecy_d = v - 4'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mux_q   <= '0;
            nd_q    <= '0;
            vecy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mux_q   <= mux_d;
            nd_q    <= nd_d;
            vecy_q  <= vecy_d;
        end
    end

    // (r+v)*32 + c never carries into the r+v field since c < 16; +16 sets bit 4.
    assign bus.AddressR  = in_win ? cnt_q[7:0]     : 8'd0;
    assign bus.AddressS1 = in_win ? {rv, 1'b0, c}  : 10'd0;
    assign bus.AddressS2 = in_win ? {rv, 1'b1, c}  : 10'd0;
    assign bus.busy      = (state_q == S_RUN);
    assign bus.completed = (state_q == S_DONE);
    assign bus.S1S2mux   = mux_q;
    assign bus.newDist   = nd_q;
    assign bus.vecY      = vecy_q;

endmodule

// File: tb/tb_me_sequencer.sv
// Directed bench for me_sequencer: reset, full search, address/strobe points,
// DONE hold, abort, asynchronous reset mid-search.
module tb_me_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    me_sequencer_if bus();

    me_sequencer dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic any_out();
        return |{bus.completed, bus.busy, bus.AddressR, bus.AddressS1, bus.AddressS2,
                 bus.S1S2mux, bus.newDist, bus.vecY};
    endfunction

    initial begin
        int nd_cnt;
        int busy_cnt;
        bit multi_bad;
        bit overlap_bad;
        bit early_done;

        nd_cnt = 0; busy_cnt = 0;
        multi_bad = 0; overlap_bad = 0; early_done = 0;

        // Reset state
        rst = 1'b1;
        bus.start = 1'b0;
        tick(); tick();
        check("reset_outs", 32'(any_out()), 0);
        rst = 1'b0;
        tick();
        check("idle_outs", 32'(any_out()), 0);

        // Full search; cnt == n at each observation
        bus.start = 1'b1;
        tick();
        check("run_busy", 32'(bus.busy), 1);
        check("run_c0_S2", 32'(bus.AddressS2), 16);
        for (int n = 0; n < 4112; n++) begin
            if (n == 'h2A5) begin
                check("addr_R_2A5", 32'(bus.AddressR), 'hA5);
                check("addr_S1_2A5", 32'(bus.AddressS1), 389);
                check("addr_S2_2A5", 32'(bus.AddressS2), 405);
            end
            if (n == 'h2A6) check("mux_2A5", 32'(bus.S1S2mux), 'h003F);
            if (n == 260) begin
                check("nd_259", 32'(bus.newDist), 'h0008);
                check("vecy_259", 32'(bus.vecY), 0);
            end
            if (n == 4095) begin
                check("addr_R_4095", 32'(bus.AddressR), 'hFF);
                check("addr_S1_4095", 32'(bus.AddressS1), 975);
                check("addr_S2_4095", 32'(bus.AddressS2), 991);
            end
            if (n == 4096)
                check("addr_drain", 32'(|{bus.AddressR, bus.AddressS1, bus.AddressS2}), 0);
            if (n == 4100) begin
                check("nd_4099", 32'(bus.newDist), 'h0008);
                check("vecy_4099", 32'(bus.vecY), 15);
            end
            nd_cnt += $countones(bus.newDist);
            if ($countones(bus.newDist) > 1) multi_bad = 1;
            if (bus.busy) busy_cnt++;
            if (bus.busy && bus.completed) overlap_bad = 1;
            if (bus.completed) early_done = 1;
            tick();
        end
        nd_cnt += $countones(bus.newDist);
        check("done_completed", 32'(bus.completed), 1);
        check("done_busy", 32'(bus.busy), 0);
        check("busy_cycles", 32'(busy_cnt), 4112);
        check("nd_4111", 32'(bus.newDist), 'h8000);
        check("vecy_4111", 32'(bus.vecY), 15);
        check("mux_4111", 32'(bus.S1S2mux), 0);
        check("nd_total", 32'(nd_cnt), 256);
        check("nd_onehot", 32'(multi_bad), 0);
        check("busy_and_done", 32'(overlap_bad), 0);
        check("done_early", 32'(early_done), 0);

        // DONE holds with start high, no restart
        repeat (3) tick();
        check("hold_completed", 32'(bus.completed), 1);
        check("hold_busy", 32'(bus.busy), 0);
        check("hold_nd", 32'(bus.newDist), 0);
        check("hold_vecy", 32'(bus.vecY), 0);
        bus.start = 1'b0;
        tick();
        check("done_to_idle", 32'(any_out()), 0);

        // Abort at cnt=500
        tick();
        bus.start = 1'b1;
        tick();
        repeat (500) tick();
        check("abort_R_500", 32'(bus.AddressR), 'hF4);
        bus.start = 1'b0;
        tick();
        check("abort_idle", 32'(any_out()), 0);
        repeat (3) tick();
        check("abort_no_done", 32'(bus.completed), 0);
        bus.start = 1'b1;
        tick();
        check("restart_busy", 32'(bus.busy), 1);
        check("restart_R", 32'(bus.AddressR), 0);
        check("restart_S2", 32'(bus.AddressS2), 16);

        // Abort on a strobe cycle leaves no pulse behind
        repeat (259) tick();
        bus.start = 1'b0;
        tick();
        check("abort_no_strobe", 32'(bus.newDist), 0);
        check("abort2_busy", 32'(bus.busy), 0);

        // Asynchronous reset at cnt=1000
        bus.start = 1'b1;
        tick();
        repeat (1000) tick();
        check("pre_rst_R", 32'(bus.AddressR), 'hE8);
        check("pre_rst_mux", 32'(bus.S1S2mux), 'h00FF);
        #2 rst = 1'b1;
        #1 check("async_rst_outs", 32'(any_out()), 0);
        tick();
        bus.start = 1'b0;
        rst = 1'b0;
        tick();
        check("post_rst_idle", 32'(any_out()), 0);
        bus.start = 1'b1;
        tick();
        check("post_rst_start", 32'(bus.busy), 1);
        check("post_rst_R", 32'(bus.AddressR), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
